// File: rtl/tap_data_path.sv
//------------------------------------------------------------------------------
// Module      : tap_data_path
// Description : JTAG TAP instruction/data register path (IR, BYPASS, USER,
//               optional IDCODE). Define TAP_IDCODE_EN to include IDCODE.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tap_data_path #(
    parameter int          IR_W       = 4,
    parameter int          USER_W     = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
    input  logic              clk,
    input  logic              TRST,
    input  logic [3:0]        tap_state,
    input  logic              TDI,
    input  logic [USER_W-1:0] user_din,
    output logic              TDO,
    output logic              tdo_en,
    output logic [IR_W-1:0]   ir_out,
    output logic [USER_W-1:0] user_dr,
    output logic              user_update
);

    localparam logic [3:0] c_ST_TLR        = 4'd0;
    localparam logic [3:0] c_ST_CAPTURE_DR = 4'd3;
    localparam logic [3:0] c_ST_SHIFT_DR   = 4'd4;
    localparam logic [3:0] c_ST_UPDATE_DR  = 4'd8;
    localparam logic [3:0] c_ST_CAPTURE_IR = 4'd10;
    localparam logic [3:0] c_ST_SHIFT_IR   = 4'd11;
    localparam logic [3:0] c_ST_UPDATE_IR  = 4'd15;

    localparam logic [IR_W-1:0] c_OP_IDCODE  = IR_W'(1);
    localparam logic [IR_W-1:0] c_OP_USER    = IR_W'(2);
    localparam logic [IR_W-1:0] c_OP_BYPASS  = '1;
    localparam logic [IR_W-1:0] c_IR_CAPTURE = IR_W'(1);

`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] c_IR_DEFAULT = c_OP_IDCODE;
`else
    localparam logic [IR_W-1:0] c_IR_DEFAULT = c_OP_BYPASS;
`endif

    // IEEE 1149.1 requires the IDCODE LSB to be 1 so it is distinguishable from BYPASS.
    if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_check
        $error("IDCODE_VAL bit 0 must be 1");
    end

    logic [IR_W-1:0]   r_ir_shift;
    logic              r_bypass;
    logic [USER_W-1:0] r_user_sr;
    logic              w_sel_user;
    logic              w_sel_bypass;
    logic              w_dr_tdo;

    assign w_sel_user = (ir_out == c_OP_USER);

`ifdef TAP_IDCODE_EN
    logic [31:0] r_idcode;
    logic        w_sel_idcode;

    assign w_sel_idcode = (ir_out == c_OP_IDCODE);
    assign w_sel_bypass = !w_sel_user && !w_sel_idcode;
`else
    assign w_sel_bypass = !w_sel_user;
`endif

    always_comb begin
        w_dr_tdo = r_bypass;
        if (w_sel_user) begin
            w_dr_tdo = r_user_sr[0];
        end
`ifdef TAP_IDCODE_EN
        if (w_sel_idcode) begin
            w_dr_tdo = r_idcode[0];
        end
`endif
    end

    // Shift registers only move in Capture/Shift; every other state holds them.
    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            ir_out      <= c_IR_DEFAULT;
            r_ir_shift  <= '0;
            r_bypass    <= 1'b0;
            r_user_sr   <= '0;
            user_dr     <= '0;
            user_update <= 1'b0;
`ifdef TAP_IDCODE_EN
            r_idcode    <= '0;
`endif
        end else begin
            user_update <= 1'b0;
            case (tap_state)
                c_ST_TLR:        ir_out     <= c_IR_DEFAULT;
                c_ST_CAPTURE_IR: r_ir_shift <= c_IR_CAPTURE;
                c_ST_SHIFT_IR:   r_ir_shift <= {TDI, r_ir_shift[IR_W-1:1]};
                c_ST_UPDATE_IR:  ir_out     <= r_ir_shift;
                c_ST_CAPTURE_DR: begin
                    if (w_sel_bypass) r_bypass  <= 1'b0;
                    if (w_sel_user)   r_user_sr <= user_din;
`ifdef TAP_IDCODE_EN
                    if (w_sel_idcode) r_idcode  <= IDCODE_VAL;
`endif
                end
                c_ST_SHIFT_DR: begin
                    if (w_sel_bypass) r_bypass  <= TDI;
                    if (w_sel_user)   r_user_sr <= {TDI, r_user_sr[USER_W-1:1]};
`ifdef TAP_IDCODE_EN
                    if (w_sel_idcode) r_idcode  <= {TDI, r_idcode[31:1]};
`endif
                end
                c_ST_UPDATE_DR: begin
                    if (w_sel_user) begin
                        user_dr     <= r_user_sr;
                        user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // TDO changes on the falling edge so the external capture on the rising edge is safe.
    always_ff @(negedge clk or posedge TRST) begin
        if (TRST) begin
            TDO    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            case (tap_state)
                c_ST_SHIFT_IR: begin
                    TDO    <= r_ir_shift[0];
                    tdo_en <= 1'b1;
                end
                c_ST_SHIFT_DR: begin
                    TDO    <= w_dr_tdo;
                    tdo_en <= 1'b1;
                end
                default: begin
                    TDO    <= 1'b0;
                    tdo_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/tap_data_path.md
TAP_DATA_PATH -- requirements
Module: tap_data_path

Interface
REQ-001 SHALL have parameter IR_W, default 4: instruction register width.
REQ-002 SHALL have parameter USER_W, default 8: user data register width.
REQ-003 SHALL have parameter IDCODE_VAL, default 32'h1234_5001: identification value; bit 0 SHALL be 1.
REQ-004 SHALL have port clk, input, 1: test clock (TCK).
REQ-005 SHALL have port TRST, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port tap_state, input, 4: current TAP controller state, driven by the TAP controller.
- Encoding 0 Test-Logic-Reset, 1 Run-Test/Idle, 2 Select-DR, 3 Capture-DR, 4 Shift-DR, 5 Exit1-DR, 6 Pause-DR, 7 Exit2-DR, 8 Update-DR.
- Encoding 9 Select-IR, 10 Capture-IR, 11 Shift-IR, 12 Exit1-IR, 13 Pause-IR, 14 Exit2-IR, 15 Update-IR.
REQ-007 SHALL have port TDI, input, 1: serial test data in.
REQ-008 SHALL have port user_din, input, USER_W: parallel capture value for the USER register.
REQ-009 SHALL have port TDO, output, 1: serial test data out.
REQ-010 SHALL have port tdo_en, output, 1: TDO valid/drive enable.
REQ-011 SHALL have port ir_out, output, IR_W: active instruction.
REQ-012 SHALL have port user_dr, output, USER_W: updated user data.
REQ-013 SHALL have port user_update, output, 1: one-cycle pulse on user_dr load.

Function
REQ-014 Instruction decode SHALL be as follows; every other opcode SHALL select BYPASS.
- IDCODE = 1.
- USER = 2.
- BYPASS = all-ones.
REQ-015 All register actions SHALL occur on posedge clk and SHALL be qualified by the tap_state value sampled at that edge.
REQ-016 IR path SHALL behave as follows.
- Capture-IR: ir_shift loads {0..0,2'b01}.
- Shift-IR: ir_shift shifts right, TDI entering the MSB.
- Update-IR: ir_out loads ir_shift; the new instruction is visible the following cycle.
REQ-017 In Test-Logic-Reset, ir_out SHALL load the default instruction every cycle.
REQ-018 BYPASS SHALL be a 1-bit register: load 0 in Capture-DR, load TDI in Shift-DR.
REQ-019 IDCODE SHALL be a 32-bit register: load IDCODE_VAL in Capture-DR; in Shift-DR shift right with TDI entering the MSB.
REQ-020 USER SHALL be a USER_W shift register.
- Capture-DR: load user_din.
- Shift-DR: shift right, TDI entering the MSB.
- Update-DR: user_dr loads the shift register, and user_update is high for exactly the next cycle.
REQ-021 Only the data register selected by ir_out SHALL capture, shift or update; unselected registers SHALL hold.
REQ-022 All shift registers SHALL hold in Exit1, Pause, Exit2, Select, Run-Test/Idle and Update states.
REQ-023 TDO and tdo_en SHALL update on negedge clk.
- tap_state=Shift-IR: TDO=ir_shift[0], tdo_en=1.
- tap_state=Shift-DR: TDO=bit 0 of the selected data register, tdo_en=1.
- Any other state: TDO=0, tdo_en=0.
REQ-024 Shifting beyond register length SHALL output previously shifted-in TDI bits in order; there is no wrap to captured data.
REQ-025 An instruction change SHALL take effect only via Update-IR or Test-Logic-Reset; a DR scan in progress SHALL use the ir_out in force at Capture-DR.

Reset
REQ-026 On TRST assertion, with no clock required:
- ir_out = default instruction.
- ir_shift, all DR shift registers and user_dr = 0.
- user_update, TDO and tdo_en = 0.
REQ-027 TRST asserted mid-scan SHALL abort the scan; no update SHALL occur for that scan.

Configuration
REQ-028 Macro TAP_IDCODE_EN defined: the IDCODE register SHALL be present, and the default instruction SHALL be IDCODE.
REQ-029 Macro TAP_IDCODE_EN undefined: there SHALL be no IDCODE register, opcode 1 SHALL select BYPASS, and the default instruction SHALL be BYPASS (all-ones).

Verification
REQ-030 TAP_IDCODE_EN defined, TRST pulse, then Capture-DR and 32 Shift-DR cycles -> TDO emits 32'h1234_5001 LSB first; tdo_en high for those 32 cycles.
REQ-031 Capture-IR, 4 Shift-IR cycles with TDI=1,1,1,1, then Update-IR -> TDO=1,0,0,0; ir_out=4'b1111 the cycle after Update-IR.
REQ-032 BYPASS selected, Capture-DR, Shift-DR with TDI=1,0,1,1 -> TDO=0,1,0,1.
REQ-033 USER selected, user_din=8'hA5, Capture-DR, 8 Shift-DR cycles with TDI=8'h3C LSB first, then Update-DR -> TDO=8'hA5 LSB first; user_dr=8'h3C; user_update high for exactly 1 cycle.
REQ-034 TRST asserted during the 2nd Shift-IR cycle -> ir_out, TDO and tdo_en return immediately to default/0; no Update-IR effect.
REQ-035 TAP_IDCODE_EN undefined, TRST, then a DR scan -> ir_out=4'b1111; the scan is a 1-bit bypass (TDO shows a leading 0, then TDI delayed by one cycle).
